rv_mem_initiator: RTL and testbench

- Bus master for the picorv32 native memory interface. It sits where the CPU would sit and drives mem_valid/addr/wdata/wstrb into the existing memory/buffer responders.
- Accepts byte/half/word read/write commands over a valid/ready port. Performs lane alignment and wstrb generation, waits for mem_ready, and returns extended read data with an error code.
- Used by the host-side loader and debug path to preload and inspect l_mem/l_buff without the CPU.

---
 rtl/rv_mem_pkg.sv | 44 ++++
 rtl/rv_mem_initiator_align.sv | 56 +++++
 rtl/rv_mem_initiator.sv | 178 +++++++++++++++++
 tb/tb_rv_mem_initiator.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared size/error codes, FSM state type and latched-command payload for the
// picorv32 native-bus initiator.
package rv_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Fields of an accepted command still needed after the handshake
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] addr_lo;
  } cmd_lat_t;

  // Reserved size code never reaches the bus
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = |addr_lo;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rv_mem_initiator_align.sv
// Byte-lane alignment for the native memory bus: write packing, strobe
// generation, read extraction/extension and misalignment detection.
module rv_lane_align
  import rv_mem_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] lane_wdata,
  output logic [STRB_W-1:0] lane_wstrb,
  output logic [DATA_W-1:0] lane_rdata,
  output logic              misaligned
);

  logic [DATA_W-1:0] shifted;

  assign misaligned = is_misaligned(size, addr_lo);
  assign shifted    = rdata >> {addr_lo, 3'b000};

  // Replicate the operand across every lane so any responder lane sees it
  always_comb begin
    lane_wdata = wdata;
    lane_wstrb = '0;
    case (size)
      SZ_BYTE: begin
        lane_wdata = {4{wdata[7:0]}};
        lane_wstrb = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        lane_wdata = {2{wdata[15:0]}};
        lane_wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        lane_wdata = wdata;
        lane_wstrb = 4'b1111;
      end
      default: begin
        lane_wdata = wdata;
        lane_wstrb = '0;
      end
    endcase
  end

  always_comb begin
    lane_rdata = '0;
    case (size)
      SZ_BYTE: lane_rdata = {{24{sgn & shifted[7]}}, shifted[7:0]};
      SZ_HALF: lane_rdata = {{16{sgn & shifted[15]}}, shifted[15:0]};
      SZ_WORD: lane_rdata = shifted;
      default: lane_rdata = '0;
    endcase
  end

endmodule

// File: rtl/rv_mem_initiator.sv
// Host-side bus master for the picorv32 native memory interface: one
// outstanding byte/half/word access with lane alignment and a bus timeout.
module rv_mem_initiator
  import rv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [1:0]        cmd_size,
  input  logic              cmd_signed,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_valid,
  output logic              mem_instr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t            state_q, state_d;
  cmd_lat_t          lat_q, lat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              cmd_ready_d;
  logic              mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic [1:0]        rsp_err_d;

  logic [1:0]        al_addr_lo;
  logic [1:0]        al_size;
  logic              al_sgn;
  logic [DATA_W-1:0] lane_wdata;
  logic [STRB_W-1:0] lane_wstrb;
  logic [DATA_W-1:0] lane_rdata;
  logic              lane_misaligned;

  assign mem_instr = 1'b0;

  // One aligner: packs the incoming command in IDLE, unpacks the latched one otherwise
  assign al_addr_lo = (state_q == IDLE) ? cmd_addr[1:0] : lat_q.addr_lo;
  assign al_size    = (state_q == IDLE) ? cmd_size     : lat_q.size;
  assign al_sgn     = (state_q == IDLE) ? cmd_signed   : lat_q.sgn;

  rv_lane_align u_align (
    .addr_lo    (al_addr_lo),
    .size       (al_size),
    .sgn        (al_sgn),
    .wdata      (cmd_wdata),
    .rdata      (mem_rdata),
    .lane_wdata (lane_wdata),
    .lane_wstrb (lane_wstrb),
    .lane_rdata (lane_rdata),
    .misaligned (lane_misaligned)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      cnt_q     <= '0;
      cmd_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      cnt_q     <= cnt_d;
      cmd_ready <= cmd_ready_d;
      mem_valid <= mem_valid_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    cnt_d       = cnt_q;
    cmd_ready_d = 1'b0;
    mem_valid_d = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_d   = 1'b0;
          lat_d.we      = cmd_we;
          lat_d.size    = cmd_size;
          lat_d.sgn     = cmd_signed;
          lat_d.addr_lo = cmd_addr[1:0];
          cnt_d         = '0;
          if (lane_misaligned) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = ERR_MISALIGN;
          end else begin
            state_d     = BUS;
            mem_valid_d = 1'b1;
            mem_addr_d  = {cmd_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = cmd_we ? lane_wdata : '0;
            mem_wstrb_d = cmd_we ? lane_wstrb : '0;
          end
        end
      end

      BUS: begin
        mem_valid_d = 1'b1;
        // A ready arriving on the expiry cycle still completes normally
        if (mem_ready) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = lat_q.we ? '0 : lane_rdata;
          rsp_err_d   = ERR_OK;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        rsp_valid_d = 1'b1;
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = ERR_OK;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_rv_mem_initiator.sv
// Directed bench for rv_mem_initiator: a byte-level reference model predicts
// bus requests, responses and latencies; a responder drives the native bus.
module tb_rv_mem_initiator;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [1:0]  cmd_size;
  logic        cmd_signed;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  rv_mem_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_size   (cmd_size),
    .cmd_signed (cmd_signed),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned nchk = 0;
  int unsigned nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder: mode 0 ready same cycle, 1 never, 2 ready on bus cycle ready_k, 3 ready stuck high
  int          resp_mode;
  int unsigned ready_k;
  int unsigned vcnt;
  logic        mem_clear;
  logic [31:0] wmem [64];

  function automatic logic [31:0] wpat(input int unsigned i);
    return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
  endfunction

  assign mem_ready = (resp_mode == 3) ? 1'b1 :
                     (mem_valid && ((resp_mode == 0) || (resp_mode == 2 && vcnt == ready_k - 1)));
  assign mem_rdata = wmem[mem_addr[7:2]];

  always @(posedge clk) begin
    vcnt <= (mem_valid && !mem_ready) ? vcnt + 1 : 0;
    if (mem_clear) begin
      for (int unsigned i = 0; i < 64; i++) wmem[i] <= wpat(i);
    end else if (mem_valid && mem_ready) begin
      for (int unsigned b = 0; b < 4; b++)
        if (mem_wstrb[b]) wmem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference model: byte-addressed memory plus expectations for the current command
  logic [7:0]  refmem [256];
  logic        exp_we, exp_mis;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_wstrb;
  logic [1:0]  exp_err;
  int unsigned e_lat, e_mv;

  function automatic int unsigned nbytes(input logic [1:0] s);
    return 32'd1 << s;
  endfunction

  function automatic logic model_mis(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || ((a % nbytes(s)) != 32'd0);
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] s, input logic [31:0] a);
    int unsigned m;
    m = ((32'd1 << nbytes(s)) - 32'd1) << (a % 32'd4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] s, input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++)
      r = r | (((d >> (8 * (i % nbytes(s)))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] s, input logic sg, input logic [31:0] a);
    int unsigned n;
    logic [31:0] v;
    n = nbytes(s);
    v = '0;
    for (int unsigned k = 0; k < n; k++) v = v | (32'(refmem[8'(a + k)]) << (8 * k));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic prepare(input logic we, input logic [1:0] s, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
    int unsigned bus;
    exp_we    = we;
    exp_addr  = a;
    exp_mis   = model_mis(s, a);
    exp_wstrb = we ? model_strb(s, a) : 4'h0;
    exp_wdata = model_wdata(s, d);
    if (exp_mis) begin
      exp_err = 2'b01;
      e_lat   = 1;
      e_mv    = 0;
    end else begin
      if (resp_mode == 1)      bus = TO;
      else if (resp_mode == 2) bus = (ready_k < TO) ? ready_k : TO;
      else                     bus = 1;
      e_mv    = bus;
      e_lat   = bus + 1;
      exp_err = ((resp_mode == 1) || (resp_mode == 2 && ready_k > TO)) ? 2'b10 : 2'b00;
    end
    exp_rdata = (!we && exp_err == 2'b00) ? model_read(s, sg, a) : 32'h0;
  endtask

  task automatic issue(input logic we, input logic [1:0] s, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    int unsigned n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_size = s; cmd_signed = sg; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      nchk++; nerr++;
      $display("FAIL accept: cmd_ready never rose, got 0 expected 1");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  logic [31:0] got_rd, cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic [1:0]  got_err;
  int unsigned got_lat, got_mv;

  task automatic finish_rsp(input int unsigned hold);
    got_lat = 1; got_mv = 0;
    cap_addr = '0; cap_wdata = '0; cap_wstrb = '0;
    while (!rsp_valid && got_lat < 40) begin
      if (mem_valid) begin
        if (got_mv == 0) begin cap_addr = mem_addr; cap_wdata = mem_wdata; cap_wstrb = mem_wstrb; end
        got_mv++;
      end
      @(negedge clk);
      got_lat++;
    end
    chk("rsp_latency", got_lat, e_lat);
    chk("bus_cycles", got_mv, e_mv);
    for (int unsigned i = 0; i < hold; i++) begin
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
    end
    got_rd = rsp_rdata; got_err = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (exp_we && exp_err == 2'b00)
      for (int unsigned k = 0; k < nbytes(cmd_size); k++)
        refmem[8'(exp_addr + k)] = 8'(cmd_wdata >> (8 * k));
  endtask

  task automatic run(input logic we, input logic [1:0] s, input logic sg,
                     input logic [31:0] a, input logic [31:0] d, input int unsigned hold);
    prepare(we, s, sg, a, d);
    issue(we, s, sg, a, d);
    finish_rsp(hold);
  endtask

  // Transaction-outstanding flag derived from observed handshakes
  logic out_q;
  logic chk_en;
  always @(posedge clk) begin
    if (!resetn)                      out_q <= 1'b0;
    else if (cmd_valid && cmd_ready)  out_q <= 1'b1;
    else if (rsp_valid && rsp_ready)  out_q <= 1'b0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!out_q));
      chk("mem_instr", 32'(mem_instr), 32'd0);
      if (!out_q) begin
        chk("idle_mem_valid", 32'(mem_valid), 32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        if (exp_mis) chk("mis_no_bus", 32'(mem_valid), 32'd0);
        if (mem_valid) begin
          chk("mem_addr", mem_addr, {exp_addr[31:2], 2'b00});
          chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
          if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
        end
        if (rsp_valid) begin
          chk("rsp_rdata", rsp_rdata, exp_rdata);
          chk("rsp_err", 32'(rsp_err), 32'(exp_err));
          chk("rsp_no_bus", 32'(mem_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_size = 2'd0; cmd_signed = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    resp_mode = 0; ready_k = 1; chk_en = 1'b0; mem_clear = 1'b1;
    for (int unsigned i = 0; i < 256; i++) refmem[i] = 8'(i);
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    resetn = 1'b1; mem_clear = 1'b0; chk_en = 1'b1;

    run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    chk("w32_addr", cap_addr, 32'h10);
    chk("w32_strb", 32'(cap_wstrb), 32'hF);
    chk("w32_err", 32'(got_err), 32'd0);
    chk("w32_lat", got_lat, 32'd2);
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    chk("r32_data", got_rd, 32'hDEADBEEF);
    chk("r32_lat", got_lat, 32'd2);

    run(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 0);
    chk("w8_strb", 32'(cap_wstrb), 32'h8);
    chk("w8_wdata", cap_wdata, 32'hA5A5A5A5);
    run(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
    chk("r8s_data", got_rd, 32'hFFFFFFA5);
    run(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
    chk("r8u_data", got_rd, 32'h000000A5);

    run(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, 0);
    chk("w16_strb", 32'(cap_wstrb), 32'hC);
    chk("w16_wdata", cap_wdata, 32'h80018001);
    run(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0);
    chk("r16s_data", got_rd, 32'hFFFF8001);

    run(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 0);
    chk("mis_err", 32'(got_err), 32'd1);
    chk("mis_rdata", got_rd, 32'd0);
    chk("mis_lat", got_lat, 32'd1);
    chk("mis_bus", got_mv, 32'd0);
    run(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 0);
    chk("sz3_err", 32'(got_err), 32'd1);

    resp_mode = 1;
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    chk("to_err", 32'(got_err), 32'd2);
    chk("to_bus", got_mv, 32'd8);
    chk("to_rdata", got_rd, 32'd0);
    resp_mode = 2; ready_k = 8;
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    chk("late_err", 32'(got_err), 32'd0);
    chk("late_data", got_rd, 32'hA5ADBEEF);
    ready_k = 9;
    run(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, 0);
    chk("to_w_err", 32'(got_err), 32'd2);
    resp_mode = 0;
    run(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);
    chk("to_w_nowrite", got_rd, 32'h80012120);

    run(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 5);
    chk("hold_data", got_rd, 32'h00008001);

    resp_mode = 3;
    run(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 0);
    chk("stray_mis_err", 32'(got_err), 32'd1);
    run(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 0);
    chk("stray_r8", got_rd, 32'h000000AD);

    resp_mode = 1;
    prepare(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    repeat (2) @(negedge clk);
    chk("rstbus_busy", 32'(mem_valid), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("rstbus_mem_valid", 32'(mem_valid), 32'd0);
    chk("rstbus_rsp_valid", 32'(rsp_valid), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rstbus_cmd_ready", 32'(cmd_ready), 32'd1);
    resp_mode = 0;
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    chk("post_rst_data", got_rd, 32'hA5ADBEEF);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
